tone_player: RTL
================

# tone_player

Parametrised multi-button tone generator driving the board piezo buzzer, LEDs and one two-digit 7-segment pair. It replaces the fixed four-button buzzer demo with several additions: per-button debouncing, a computed tone table, deterministic priority and button switching, a hold/one-shot mode, and a fully synchronous datapath clocked by the system clock. The block sits between the push-button pins and the existing `hexdigit` decoders, which consume its digit codes.

## Interface
- `NBTN`, 4, number of push buttons (1..16), active-low
- `DIV_BASE`, 2500, tone half-period for button 0, in `clk` cycles (≥2)
- `DIV_STEP`, 700, half-period increment per button index
- `DEB_CYCLES`, 100000, cycles a synchronised button level must stay stable before it is accepted
- `BURST_CYCLES`, 2000000, tone length in one-shot mode, in `clk` cycles (≥1)
- `CW`, 26, width of the divider and burst counters; `DIV_BASE+(NBTN-1)*DIV_STEP` and `BURST_CYCLES` must fit in `CW` bits
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `mode`  in  1  0 = hold (tone while pressed), 1 = one-shot burst
- `stbtn`  in  NBTN  push buttons, 0 = pressed, asynchronous
- `stled`  out  NBTN  one-hot index of the sounding button
- `dig_hi`  out  5  `hexdigit` code, upper digit
- `dig_lo`  out  5  `hexdigit` code, lower digit
- `stbuz`  out  1  square-wave buzzer drive
- `busy`  out  1  high while not IDLE

## Operation
- **Input conditioning:** each `stbtn[i]` passes through a 2-flop synchroniser, then a per-button stability counter. `db[i]` (1 = pressed) takes the new level only after `DEB_CYCLES` consecutive cycles of the same synchronised level. Reset clears `db` to 0 and clears the counters.
- **Selection:** `low` is the lowest index with `db[i]=1`. Tone half-period `hp = DIV_BASE + idx*DIV_STEP`, computed in `CW` bits. Output frequency is `clk/(2*hp)`.
- **FSM states:** IDLE, PLAY, GAP.
- **IDLE:** `stbuz=0`. When any `db` is set: latch `idx=low`, latch `mode`, clear the phase and burst counters, go to PLAY.
- **PLAY:** the phase counter increments each cycle. At `hp-1` it clears and `stbuz` toggles.
  - **Hold mode:**
    - If a lower index than `idx` becomes pressed, `idx` switches to it the same cycle. The phase counter clears; `stbuz` keeps its level.
    - If `db[idx]` drops while another button is held, `idx` switches to `low` with the same rule.
    - If no button is held, go to IDLE with `stbuz=0`.
  - **One-shot mode:** button changes are ignored. The burst counter counts `BURST_CYCLES` cycles in PLAY, then the FSM goes to GAP.
- **GAP (one-shot only):** `stbuz=0`. Stays until all `db` are 0, then goes to IDLE. A new burst therefore requires release and a fresh press.
- `mode` is sampled only on the IDLE→PLAY transition.
- **Display and indicators:**
  - PLAY: `dig_hi=11` ("b"), `dig_lo=idx`, `stled` one-hot of `idx`.
  - IDLE/GAP: `dig_hi=dig_lo=20` (blank), `stled=0`.
- **Reset values** (all outputs registered): `stbuz=0`, `stled=0`, `dig_hi=dig_lo=20`, `busy=0`, FSM=IDLE.
- **Reset mid-operation:** all reset values appear on the cycle after `rst` is sampled high, regardless of state. A button held through reset must re-debounce before it is seen.

## Timing
- **Press to PLAY:** a `stbtn` edge reaches `db` after 2 (synchroniser) + `DEB_CYCLES` + 1 cycles. The FSM enters PLAY, and the outputs update, one cycle later.
- **First toggle:** the first `stbuz` toggle occurs `hp` cycles after PLAY entry; `stbuz` is 0 on entry from IDLE.
- **Full period:** one full `stbuz` period is exactly `2*hp` cycles with no jitter while `idx` is stable.
- **One-shot length:** `stbuz` is active for exactly `BURST_CYCLES` cycles. GAP is entered on the following cycle with `stbuz=0`.
- **Release to silence:** hold-mode release reaches IDLE `DEB_CYCLES+4` cycles after the `stbtn` edge.
- **Simultaneous presses:** buttons debounced in the same cycle select the lowest index.

## Test plan
All scenarios use `NBTN=4`, `DIV_BASE=4`, `DIV_STEP=2`, `DEB_CYCLES=3`, `BURST_CYCLES=40`.
- **Reset:** `rst` high 2 cycles, all `stbtn=1` -> `stbuz=0`, `stled=0000`, `dig_hi=dig_lo=20`, `busy=0`.
- **Hold tone:** `mode=0`, `stbtn[2]=0` held -> PLAY 7 cycles after the edge, `stled=0100`, digits 11/2, `stbuz` period 16 cycles (8 high/8 low). Release -> `stbuz=0`, `busy=0` 7 cycles after the release edge.
- **Bounce rejection:** `stbtn[1]` low for 2 cycles, then high -> no state change, `busy` stays 0.
- **Priority switching:** hold `stbtn[3]` (period 20), then press `stbtn[1]` -> `idx=1`, period 12, `stled=0010`. Release `stbtn[1]` -> `idx=3`, period 20, with no gap in PLAY.
- **One-shot:** `mode=1`, `stbtn[0]` held for 200 cycles -> exactly 40 cycles of tone (5 periods of 8), then `busy=1`, `stbuz=0`, digits 20/20 until release, then IDLE. No second burst occurs without a new press.
- **Reset mid-tone:** `rst` pulsed mid-tone -> next cycle all reset values. The button still held re-enters PLAY only after a full debounce interval.

Source files
------------

// File: rtl/tone_player.sv
// Multi-button tone generator: debounced active-low buttons pick a square-wave
// pitch for the buzzer, with hold or one-shot burst playback and a 2-digit display.
module tone_player #(
   parameter int NBTN         = 4,
   parameter int DIV_BASE     = 2500,
   parameter int DIV_STEP     = 700,
   parameter int DEB_CYCLES   = 100000,
   parameter int BURST_CYCLES = 2000000,
   parameter int CW           = 26
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mode,
   input  logic [NBTN-1:0] stbtn,
   output logic [NBTN-1:0] stled,
   output logic [4:0]      dig_hi,
   output logic [4:0]      dig_lo,
   output logic            stbuz,
   output logic            busy
);

   localparam int IW = (NBTN > 1) ? $clog2(NBTN) : 1;
   localparam int DW = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;
   localparam logic [DW-1:0] DEB_MAX    = DW'(DEB_CYCLES);
   localparam logic [CW-1:0] BURST_LAST = CW'(BURST_CYCLES - 1);
   localparam logic [4:0]    DIG_B      = 5'd11;
   localparam logic [4:0]    DIG_BLANK  = 5'd20;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   // ---------------- input conditioning ----------------
   logic [NBTN-1:0] sync1_q, sync1_d;
   logic [NBTN-1:0] sync2_q, sync2_d;
   logic [NBTN-1:0] lvl_q, lvl_d;
   logic [NBTN-1:0] db_q, db_d;
   logic [DW-1:0]   cnt_q [NBTN];
   logic [DW-1:0]   cnt_d [NBTN];

   // lvl_q holds the previous synchronised level; cnt_q counts how long it has
   // matched, and db_q only follows lvl_q once that run reaches DEB_CYCLES.
   always_comb begin
      sync1_d = ~stbtn;
      sync2_d = sync1_q;
      lvl_d   = sync2_q;
      db_d    = db_q;
      for (int i = 0; i < NBTN; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] != lvl_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] != DEB_MAX) begin
            cnt_d[i] = cnt_q[i] + DW'(1);
         end
         if (cnt_q[i] == DEB_MAX) begin
            db_d[i] = lvl_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         lvl_q   <= '0;
         db_q    <= '0;
         for (int i = 0; i < NBTN; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         lvl_q   <= lvl_d;
         db_q    <= db_d;
         for (int i = 0; i < NBTN; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // ---------------- selection and tone table ----------------
   logic [IW-1:0] low;
   logic          any_db;
   logic [CW-1:0] hp_tab [NBTN];

   always_comb begin
      low    = '0;
      any_db = |db_q;
      for (int i = NBTN - 1; i >= 0; i--) begin
         if (db_q[i]) begin
            low = IW'(i);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NBTN; i++) begin
         hp_tab[i] = CW'(DIV_BASE) + CW'(i) * CW'(DIV_STEP);
      end
   end

   // ---------------- playback FSM ----------------
   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            mode_q, mode_d;
   logic [CW-1:0]   phase_q, phase_d;
   logic [CW-1:0]   burst_q, burst_d;
   logic            buz_q, buz_d;
   logic [NBTN-1:0] led_q, led_d;
   logic [4:0]      hi_q, hi_d;
   logic [4:0]      lo_q, lo_d;
   logic            busy_q, busy_d;
   logic [CW-1:0]   hp_cur;

   assign hp_cur = hp_tab[idx_q];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mode_d  = mode_q;
      phase_d = phase_q;
      burst_d = burst_q;
      buz_d   = buz_q;
      case (state_q)
         IDLE: begin
            buz_d = 1'b0;
            if (any_db) begin
               state_d = PLAY;
               idx_d   = low;
               mode_d  = mode;
               phase_d = '0;
               burst_d = '0;
            end
         end
         PLAY: begin
            if (phase_q == hp_cur - CW'(1)) begin
               phase_d = '0;
               buz_d   = ~buz_q;
            end else begin
               phase_d = phase_q + CW'(1);
            end
            if (!mode_q) begin
               if (!any_db) begin
                  state_d = IDLE;
                  buz_d   = 1'b0;
                  phase_d = '0;
               end else if (low != idx_q) begin
                  // Either a lower button arrived or idx was released: a pitch
                  // change restarts the half-period but keeps the buzzer level.
                  idx_d   = low;
                  phase_d = '0;
                  buz_d   = buz_q;
               end
            end else begin
               if (burst_q == BURST_LAST) begin
                  state_d = GAP;
                  buz_d   = 1'b0;
               end else begin
                  burst_d = burst_q + CW'(1);
               end
            end
         end
         GAP: begin
            buz_d = 1'b0;
            if (!any_db) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            buz_d   = 1'b0;
         end
      endcase

      led_d  = '0;
      hi_d   = DIG_BLANK;
      lo_d   = DIG_BLANK;
      busy_d = (state_d != IDLE);
      if (state_d == PLAY) begin
         led_d = NBTN'(1) << idx_d;
         hi_d  = DIG_B;
         lo_d  = 5'(idx_d);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         mode_q  <= 1'b0;
         phase_q <= '0;
         burst_q <= '0;
         buz_q   <= 1'b0;
         led_q   <= '0;
         hi_q    <= DIG_BLANK;
         lo_q    <= DIG_BLANK;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mode_q  <= mode_d;
         phase_q <= phase_d;
         burst_q <= burst_d;
         buz_q   <= buz_d;
         led_q   <= led_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
      end
   end

   assign stbuz  = buz_q;
   assign stled  = led_q;
   assign dig_hi = hi_q;
   assign dig_lo = lo_q;
   assign busy   = busy_q;

endmodule
